// File: rtl/card_pkg.sv
// Shared types, deck size and index-to-card helpers for the Blackjack card deck dealer.
package card_pkg;

  localparam int DECK_SIZE = 52;

  typedef logic [3:0] card_value_t;
  typedef logic [5:0] card_idx_t;

  typedef enum logic [1:0] {
    SUIT_SPADES   = 2'd0,
    SUIT_HEARTS   = 2'd1,
    SUIT_DIAMONDS = 2'd2,
    SUIT_CLUBS    = 2'd3
  } suit_t;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    SHUFFLE = 2'd1,
    READY   = 2'd2
  } state_t;

  function automatic card_value_t idx_to_value(input card_idx_t idx);
    card_idx_t rem;
    rem = idx % 6'd13;
    return card_value_t'(rem) + card_value_t'(1);
  endfunction

  function automatic suit_t idx_to_suit(input card_idx_t idx);
    card_idx_t quo;
    quo = idx / 6'd13;
    return suit_t'(quo[1:0]);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), reloaded with seed on reset, advancing every cycle.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = {1'b0, q_q[15:1]};
    if (q_q[0]) q_d = q_d ^ 16'hB400;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= seed;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/card_deck_dealer.sv
// 52-card deck: Fisher-Yates shuffle driven by an LFSR, deals one card per draw_req.
// Optional macro AUTO_RESHUFFLE_EN: a draw on an empty deck reshuffles and serves the draw.
module card_deck_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shuffle_req,
  input  logic       draw_req,
  output logic       ready,
  output logic       card_valid,
  output logic [3:0] card_value,
  output logic [1:0] card_suit,
  output logic [5:0] cards_left,
  output logic       draw_err
);

  state_t      state_q, state_d;
  card_idx_t   i_q, i_d;
  logic [5:0]  left_q, left_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  card_value_t value_q, value_d;
  suit_t       suit_q, suit_d;
`ifdef AUTO_RESHUFFLE_EN
  logic        pend_q, pend_d;
`endif

  card_idx_t   deck_q [DECK_SIZE];
  logic        deck_init, do_swap;
  logic [15:0] lfsr_q;
  card_idx_t   r;
  card_idx_t   deal_pos, deal_card;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign r           = lfsr_q[5:0];
  assign unused_lfsr = ^lfsr_q[15:6];
  // Cards are dealt from the front of the shuffled deck.
  assign deal_pos    = card_idx_t'(DECK_SIZE) - left_q;
  assign deal_card   = deck_q[deal_pos];

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    left_d    = left_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    value_d   = value_q;
    suit_d    = suit_q;
    deck_init = 1'b0;
    do_swap   = 1'b0;
`ifdef AUTO_RESHUFFLE_EN
    pend_d    = pend_q;
`endif
    case (state_q)
      INIT: begin
        deck_init = 1'b1;
        i_d       = card_idx_t'(DECK_SIZE - 1);
        left_d    = 6'(DECK_SIZE);
        state_d   = SHUFFLE;
      end
      SHUFFLE: begin
        if (r <= i_q) begin
          do_swap = 1'b1;
          i_d     = i_q - 6'd1;
          if (i_q == 6'd1) begin
            state_d = READY;
            ready_d = 1'b1;
          end
        end
      end
      READY: begin
        if (shuffle_req) begin
          ready_d = 1'b0;
          state_d = INIT;
`ifdef AUTO_RESHUFFLE_EN
        end else if (draw_req || pend_q) begin
          if (left_q != 6'd0) begin
            valid_d = 1'b1;
            value_d = idx_to_value(deal_card);
            suit_d  = idx_to_suit(deal_card);
            left_d  = left_q - 6'd1;
            pend_d  = 1'b0;
          end else begin
            pend_d  = 1'b1;
            ready_d = 1'b0;
            state_d = INIT;
          end
        end
`else
        end else if (draw_req) begin
          if (left_q != 6'd0) begin
            valid_d = 1'b1;
            value_d = idx_to_value(deal_card);
            suit_d  = idx_to_suit(deal_card);
            left_d  = left_q - 6'd1;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      i_q     <= '0;
      left_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      value_q <= '0;
      suit_q  <= SUIT_SPADES;
`ifdef AUTO_RESHUFFLE_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      left_q  <= left_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      value_q <= value_d;
      suit_q  <= suit_d;
`ifdef AUTO_RESHUFFLE_EN
      pend_q  <= pend_d;
`endif
    end
  end

  // Deck contents need no reset: INIT always rebuilds them before use.
  always_ff @(posedge clk) begin
    if (deck_init) begin
      for (int k = 0; k < DECK_SIZE; k++) deck_q[k] <= card_idx_t'(k);
    end else if (do_swap) begin
      deck_q[i_q] <= deck_q[r];
      deck_q[r]   <= deck_q[i_q];
    end
  end

  assign ready      = ready_q;
  assign card_valid = valid_q;
  assign card_value = value_q;
  assign card_suit  = suit_q;
  assign cards_left = left_q;
  assign draw_err   = err_q;

endmodule

// File: tb/tb_card_deck_dealer.sv
// Self-checking bench for card_deck_dealer: table-driven deal vectors plus hand-written corner sequences.
module tb_card_deck_dealer;

  logic       clk = 1'b0;
  logic       reset;
  logic       shuffle_req;
  logic       draw_req;
  logic       ready;
  logic       card_valid;
  logic [3:0] card_value;
  logic [1:0] card_suit;
  logic [5:0] cards_left;
  logic       draw_err;

  int n_checks = 0;
  int n_errors = 0;

  int mdeck [52];
  int seq_cur [52];
  int seq1 [52];
  bit seen [52];
  int dealt;
  int ncyc_model;

  typedef struct {
    bit shuf;
    bit draw;
    bit exp_valid;
    bit exp_err;
    bit exp_ready;
    int exp_left;
  } vec_t;

  vec_t vecs [6];

  card_deck_dealer #(.LFSR_SEED(16'hACE1)) dut (
    .clk         (clk),
    .reset       (reset),
    .shuffle_req (shuffle_req),
    .draw_req    (draw_req),
    .ready       (ready),
    .card_valid  (card_valid),
    .card_value  (card_value),
    .card_suit   (card_suit),
    .cards_left  (cards_left),
    .draw_err    (draw_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit s, input bit d);
    shuffle_req = s;
    draw_req    = d;
    step();
    shuffle_req = 1'b0;
    draw_req    = 1'b0;
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference Fisher-Yates run starting from a freshly reset LFSR.
  task automatic model_shuffle(output int ncyc);
    logic [15:0] l;
    int i, r, t;
    bit done;
    for (int k = 0; k < 52; k++) mdeck[k] = k;
    l = 16'hACE1;
    l = lstep(l);
    i = 51;
    ncyc = 0;
    done = 1'b0;
    while (!done && ncyc < 100000) begin
      ncyc++;
      r = int'(l[5:0]);
      if (r <= i) begin
        t = mdeck[i]; mdeck[i] = mdeck[r]; mdeck[r] = t;
        if (i == 1) done = 1'b1;
        i--;
      end
      l = lstep(l);
    end
  endtask

  task automatic wait_ready(input int limit, output int cnt);
    cnt = 0;
    while (!ready && cnt < limit) begin
      step();
      cnt++;
    end
    chk("ready_rise", int'(ready), 1);
  endtask

  task automatic clear_deal();
    for (int k = 0; k < 52; k++) seen[k] = 1'b0;
    dealt = 0;
  endtask

  task automatic note_card(input bit use_model);
    int idx;
    idx = int'(card_suit) * 13 + int'(card_value) - 1;
    chk("card_in_range", int'(card_value >= 1 && card_value <= 13), 1);
    if (idx >= 0 && idx < 52 && dealt < 52) begin
      chk("card_unique", int'(seen[idx]), 0);
      seen[idx] = 1'b1;
      if (use_model) chk("card_vs_model", idx, mdeck[dealt]);
      seq_cur[dealt] = idx;
    end
    dealt++;
  endtask

  initial begin
    int cnt;
    int last_val, last_suit;
    reset       = 1'b1;
    shuffle_req = 1'b0;
    draw_req    = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 52};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 51};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 50};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 50};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 49};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 49};

    model_shuffle(ncyc_model);

    // Reset state
    repeat (3) step();
    chk("rst_ready", int'(ready), 0);
    chk("rst_valid", int'(card_valid), 0);
    chk("rst_value", int'(card_value), 0);
    chk("rst_suit", int'(card_suit), 0);
    chk("rst_left", int'(cards_left), 0);
    chk("rst_err", int'(draw_err), 0);

    reset = 1'b0;
    step();
    chk("init_left", int'(cards_left), 52);
    chk("init_ready", int'(ready), 0);
    wait_ready(5000, cnt);
    chk("shuffle_cycles", cnt, ncyc_model);
    chk("ready_left", int'(cards_left), 52);

    // Table-driven deal vectors on the fresh deck
    clear_deal();
    last_val  = 0;
    last_suit = 0;
    for (int v = 0; v < 6; v++) begin
      cyc(vecs[v].shuf, vecs[v].draw);
      chk("vec_valid", int'(card_valid), int'(vecs[v].exp_valid));
      chk("vec_err", int'(draw_err), int'(vecs[v].exp_err));
      chk("vec_ready", int'(ready), int'(vecs[v].exp_ready));
      chk("vec_left", int'(cards_left), vecs[v].exp_left);
      if (vecs[v].exp_valid) begin
        note_card(1'b1);
        last_val  = int'(card_value);
        last_suit = int'(card_suit);
      end else if (v > 0) begin
        chk("value_hold", int'(card_value), last_val);
        chk("suit_hold", int'(card_suit), last_suit);
      end
    end

    for (int k = 0; k < 49; k++) begin
      cyc(1'b0, 1'b1);
      chk("drain_valid", int'(card_valid), 1);
      chk("drain_left", int'(cards_left), 48 - k);
      note_card(1'b1);
    end
    chk("deck1_count", dealt, 52);
    for (int k = 0; k < 52; k++) seq1[k] = seq_cur[k];

`ifndef AUTO_RESHUFFLE_EN
    // Draw on an empty deck
    cyc(1'b0, 1'b1);
    chk("empty_err", int'(draw_err), 1);
    chk("empty_valid", int'(card_valid), 0);
    chk("empty_left", int'(cards_left), 0);
    chk("empty_ready", int'(ready), 1);
    cyc(1'b0, 1'b0);
    chk("empty_err_pulse", int'(draw_err), 0);
    chk("empty_ready2", int'(ready), 1);
`else
    // Draw on an empty deck triggers an automatic reshuffle and deal
    begin
      int pulses, err_seen, ready_at, left_at, budget;
      cyc(1'b0, 1'b1);
      chk("auto_ready_drop", int'(ready), 0);
      chk("auto_no_valid", int'(card_valid), 0);
      pulses = 0; err_seen = int'(draw_err); ready_at = -1; left_at = -1; budget = 0;
      while (pulses == 0 && budget < 5000) begin
        step();
        budget++;
        if (draw_err) err_seen++;
        if (card_valid) begin
          pulses++;
          ready_at = int'(ready);
          left_at  = int'(cards_left);
        end
      end
      repeat (10) begin
        step();
        if (draw_err) err_seen++;
        if (card_valid) pulses++;
      end
      chk("auto_pulses", pulses, 1);
      chk("auto_ready_at", ready_at, 1);
      chk("auto_left_at", left_at, 51);
      chk("auto_err", err_seen, 0);
    end
`endif

    // Same seed and timing after reset gives the same deck order
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    wait_ready(5000, cnt);
    chk("shuffle_cycles2", cnt, ncyc_model);
    clear_deal();
    for (int k = 0; k < 52; k++) begin
      cyc(1'b0, 1'b1);
      chk("deck2_valid", int'(card_valid), 1);
      note_card(1'b1);
      chk("repeat_seq", seq_cur[k], seq1[k]);
    end
    chk("deck2_left", int'(cards_left), 0);

    // shuffle_req beats a same-cycle draw_req
    cyc(1'b1, 1'b1);
    chk("sd_valid", int'(card_valid), 0);
    chk("sd_err", int'(draw_err), 0);
    chk("sd_ready", int'(ready), 0);
    step();
    chk("sd_init_left", int'(cards_left), 52);
    wait_ready(5000, cnt);
    chk("sd_left", int'(cards_left), 52);

    // Reset for one cycle in the middle of a shuffle
    cyc(1'b1, 1'b0);
    chk("mid_ready_drop", int'(ready), 0);
    repeat (6) step();
    chk("mid_still_shuffling", int'(ready), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_ready", int'(ready), 0);
    chk("mid_rst_valid", int'(card_valid), 0);
    chk("mid_rst_value", int'(card_value), 0);
    chk("mid_rst_suit", int'(card_suit), 0);
    chk("mid_rst_left", int'(cards_left), 0);
    chk("mid_rst_err", int'(draw_err), 0);
    step();
    chk("mid_init_left", int'(cards_left), 52);
    wait_ready(5000, cnt);
    chk("mid_shuffle_cycles", cnt, ncyc_model);
    chk("mid_left", int'(cards_left), 52);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
